// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bus for mux_rr_arbiter. The slave modport is the arbiter
// side; the master modport is the side that drives requests and out_ready.
interface mux_rr_arbiter_if #(
  parameter int DW = 8
);
  logic          req_a;
  logic [DW-1:0] data_a;
  logic          req_b;
  logic [DW-1:0] data_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          sel;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  // Handshakes: a requester word moves when req_x & gnt_x on a rising edge; the
  // output word moves when out_valid & out_ready. A requester holds data_x stable
  // while req_x is high and not granted; out_data holds while out_valid & !out_ready.
  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, sel, out_valid, out_data
  );

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  gnt_a, gnt_b, sel, out_valid, out_data
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter steering a shared 2:1 mux into a one-entry
// output register. Optional grant counters are enabled by MUX_RR_GRANT_CNT_EN.
module mux_rr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus,
  output logic [1:0]        dbg_state_o
`ifdef MUX_RR_GRANT_CNT_EN
  ,
  output logic [15:0]       gnt_cnt_a,
  output logic [15:0]       gnt_cnt_b
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam int            CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  logic [1:0]    state_q, state_d;
  logic          last_b_q, last_b_d;  // 1 when B was the most recent owner
  logic [CW-1:0] burst_q, burst_d;
  logic          sel_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;

  logic space, gnt_a, gnt_b, gnt;
  logic own_is_b, own_req, oth_req;
  logic [1:0] other_state;

  assign space = !out_valid_q || bus.out_ready;
  assign gnt_a = (state_q == OWN_A) && bus.req_a && space;
  assign gnt_b = (state_q == OWN_B) && bus.req_b && space;
  assign gnt   = gnt_a || gnt_b;

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    burst_d     = burst_q;
    own_is_b    = (state_q == OWN_B);
    own_req     = own_is_b ? bus.req_b : bus.req_a;
    oth_req     = own_is_b ? bus.req_a : bus.req_b;
    other_state = own_is_b ? OWN_A : OWN_B;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (bus.req_a && bus.req_b) begin
          state_d = last_b_q ? OWN_A : OWN_B;
        end else if (bus.req_a) begin
          state_d = OWN_A;
        end else if (bus.req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req) begin
          last_b_d = own_is_b;
          burst_d  = '0;
          state_d  = oth_req ? other_state : IDLE;
        end else if (gnt) begin
          // Allowance used up: hand over if the other side waits, else restart it.
          if (burst_q == LAST_BEAT) begin
            last_b_d = own_is_b;
            burst_d  = '0;
            if (oth_req) state_d = other_state;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      burst_q  <= '0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      burst_q  <= burst_d;
      sel_q    <= (state_d == OWN_B);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (gnt) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_q ? bus.data_b : bus.data_a;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MUX_RR_GRANT_CNT_EN
  logic [15:0] gnt_cnt_a_q, gnt_cnt_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_a_q <= '0;
      gnt_cnt_b_q <= '0;
    end else begin
      if (gnt_a) gnt_cnt_a_q <= gnt_cnt_a_q + 16'd1;
      if (gnt_b) gnt_cnt_b_q <= gnt_cnt_b_q + 16'd1;
    end
  end

  assign gnt_cnt_a = gnt_cnt_a_q;
  assign gnt_cnt_b = gnt_cnt_b_q;
`endif

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic, compared
// every cycle against an ownership/allowance model and an expected-word queue.
module tb_mux_rr_arbiter;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.DW(DW)) intf ();
  logic [1:0] dbg_state;
`ifdef MUX_RR_GRANT_CNT_EN
  logic [15:0] gnt_cnt_a, gnt_cnt_b;
`endif

  mux_rr_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (intf),
    .dbg_state_o (dbg_state)
`ifdef MUX_RR_GRANT_CNT_EN
    ,
    .gnt_cnt_a   (gnt_cnt_a),
    .gnt_cnt_b   (gnt_cnt_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: owner 0=none 1=A 2=B, last = most recent owner, budget = grants left.
  logic [DW-1:0] exp_q[$];
  int  grant_log[$];
  int  m_own, m_last, m_budget;
  int  n_own, n_last, n_budget;
  int  tot_ga, tot_gb;
  bit  full, space, e_ga, e_gb, mine, other;

  logic          ga, gb;
  logic [DW-1:0] prev_a, prev_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    m_own = 0; m_last = 2; m_budget = MB; tot_ga = 0; tot_gb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_gnt_a", {31'd0, intf.gnt_a}, 0);
        check("rst_gnt_b", {31'd0, intf.gnt_b}, 0);
        check("rst_sel", {31'd0, intf.sel}, 0);
        check("rst_out_valid", {31'd0, intf.out_valid}, 0);
        check("rst_out_data", {24'd0, intf.out_data}, 0);
        n_own = 0; n_last = 2; n_budget = MB;
      end else begin
        full  = (exp_q.size() != 0);
        space = !full || intf.out_ready;
        e_ga  = (m_own == 1) && intf.req_a && space;
        e_gb  = (m_own == 2) && intf.req_b && space;
        check("gnt_a", {31'd0, intf.gnt_a}, {31'd0, e_ga});
        check("gnt_b", {31'd0, intf.gnt_b}, {31'd0, e_gb});
        check("sel", {31'd0, intf.sel}, (m_own == 2) ? 1 : 0);
        check("out_valid", {31'd0, intf.out_valid}, {31'd0, full});
        check("state", {30'd0, dbg_state}, m_own);
        if (full) check("out_data", {24'd0, intf.out_data}, {24'd0, exp_q[0]});
        if (full && intf.out_ready) void'(exp_q.pop_front());
        if (e_ga) begin exp_q.push_back(intf.data_a); grant_log.push_back(1); tot_ga++; end
        if (e_gb) begin exp_q.push_back(intf.data_b); grant_log.push_back(2); tot_gb++; end

        n_own = m_own; n_last = m_last; n_budget = m_budget;
        if (m_own == 0) begin
          n_budget = MB;
          if (intf.req_a && intf.req_b) n_own = (m_last == 2) ? 1 : 2;
          else if (intf.req_a) n_own = 1;
          else if (intf.req_b) n_own = 2;
        end else begin
          mine  = (m_own == 1) ? intf.req_a : intf.req_b;
          other = (m_own == 1) ? intf.req_b : intf.req_a;
          if (!mine) begin
            n_last = m_own; n_budget = MB;
            n_own  = other ? 3 - m_own : 0;
          end else if (e_ga || e_gb) begin
            n_budget = m_budget - 1;
            if (n_budget == 0) begin
              n_last = m_own; n_budget = MB;
              if (other) n_own = 3 - m_own;
            end
          end
        end
      end
      @(posedge clk);
      if (!rst_n) begin
        m_own = 0; m_last = 2; m_budget = MB;
        exp_q.delete(); tot_ga = 0; tot_gb = 0;
      end else begin
        m_own = n_own; m_last = n_last; m_budget = n_budget;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    ga = intf.gnt_a;
    gb = intf.gnt_b;
    @(posedge clk);
    #1;
    if (ga) begin prev_a = intf.data_a; intf.data_a = 8'($urandom); end
    if (gb) begin prev_b = intf.data_b; intf.data_b = 8'($urandom); end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    intf.req_a = 1'b0; intf.req_b = 1'b0;
    intf.data_a = '0;  intf.data_b = '0;
    intf.out_ready = 1'b1;
    prev_a = '0; prev_b = '0;

    // Reset, then A alone with 8'h11
    repeat (3) @(posedge clk);
    #1;
    check("t1_rst_valid", {31'd0, intf.out_valid}, 0);
    rst_n = 1'b1;
    intf.data_a = 8'h11;
    intf.req_a  = 1'b1;
    @(posedge clk); #1;
    check("t1_gnt_a_cycle2", {31'd0, intf.gnt_a}, 1);
    check("t1_sel_c2", {31'd0, intf.sel}, 0);
    @(posedge clk); #1;
    intf.req_a = 1'b0;
    check("t1_valid_c3", {31'd0, intf.out_valid}, 1);
    check("t1_data_c3", {24'd0, intf.out_data}, 32'h11);
    check("t1_sel_c3", {31'd0, intf.sel}, 0);
    repeat (2) step();

    // Fairness: both requesting, expect AAAA BBBB AAAA
    pulse_reset();
    intf.data_a = 8'hA0; intf.data_b = 8'hB0;
    intf.req_a = 1'b1; intf.req_b = 1'b1;
    grant_log.delete();
    repeat (13) step();
    intf.req_a = 1'b0; intf.req_b = 1'b0;
    check("fair_len", grant_log.size(), 12);
    for (int i = 0; i < 12; i++)
      check("fair_seq", grant_log[i], (((i / MB) % 2) == 1) ? 2 : 1);
    repeat (2) step();

    // Backpressure in the middle of an A burst
    intf.req_a = 1'b1;
    repeat (3) step();
    intf.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_gnt_a", {31'd0, intf.gnt_a}, 0);
      check("bp_hold", {24'd0, intf.out_data}, {24'd0, prev_a});
      @(posedge clk); #1;
    end
    intf.out_ready = 1'b1;
    repeat (4) step();
    intf.req_a = 1'b0;
    repeat (2) step();

    // B drops after two transfers; A then gets a full allowance
    intf.req_b = 1'b1;
    repeat (3) step();
    intf.req_b = 1'b0; intf.req_a = 1'b1;
    step();
    check("bd_sel", {31'd0, intf.sel}, 0);
    check("bd_state", {30'd0, dbg_state}, 1);
    intf.req_b = 1'b1;
    grant_log.delete();
    repeat (6) step();
    for (int i = 0; i < MB; i++) check("bd_a_allow", grant_log[i], 1);
    check("bd_then_b", grant_log[MB], 2);

    // Asynchronous reset mid-burst
    step();
    check("mr_pre_valid", {31'd0, intf.out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, intf.out_valid}, 0);
    check("mr_sel", {31'd0, intf.sel}, 0);
    check("mr_gnt_a", {31'd0, intf.gnt_a}, 0);
    check("mr_gnt_b", {31'd0, intf.gnt_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_log.delete();
    repeat (2) step();
    check("mr_first_a", grant_log.size() > 0 ? grant_log[0] : 0, 1);

    // Random traffic with occasional backpressure
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!intf.req_a) intf.data_a = 8'($urandom);
      if (!intf.req_b) intf.data_b = 8'($urandom);
      if (!intf.req_a || ga) intf.req_a = ($urandom_range(0, 9) < 7);
      if (!intf.req_b || gb) intf.req_b = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) intf.req_a = 1'b0;
      if ($urandom_range(0, 15) == 0) intf.req_b = 1'b0;
      intf.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain
    intf.req_a = 1'b0; intf.req_b = 1'b0; intf.out_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", {31'd0, intf.out_valid}, 0);
`ifdef MUX_RR_GRANT_CNT_EN
    check("cnt_a", {16'd0, gnt_cnt_a}, tot_ga % 65536);
    check("cnt_b", {16'd0, gnt_cnt_b}, tot_gb % 65536);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
